// File: rtl/vec_cache_wdb_alloc_pkg.sv
// Shared sizing and slot type for the vector cache write-data-buffer allocator.
package vector_cache_pkg;

  localparam int DB_ENTRY_NUM       = 32;
  localparam int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM);
  localparam int WDB_LANE_NUM       = 4;

  typedef struct packed {
    logic                          vld;
    logic [DB_ENTRY_IDX_WIDTH-1:0] idx;
  } wdb_alloc_slot_t;

endpackage

// File: rtl/vec_cache_wdb_alloc_pick.sv
// Masked find-first-set: lowest index set in avail_i and not set in mask_i.
module vec_cache_wdb_pick
  import vector_cache_pkg::*;
#(
  parameter int N  = DB_ENTRY_NUM,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  avail_i,
  input  logic [N-1:0]  mask_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] cand;

  assign cand = avail_i & ~mask_i;

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vec_cache_wdb_alloc.sv
// WDB entry allocator: free list, one pre-fetched entry per write lane, rotating refill priority.
// Optional release checking and assertions: define VEC_CACHE_WDB_ALLOC_CHK_EN.
module vec_cache_wdb_alloc #(
  parameter int DB_ENTRY_NUM = vector_cache_pkg::DB_ENTRY_NUM,
  parameter int REL_NUM      = 4,
  localparam int IW          = $clog2(DB_ENTRY_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [3:0]            alloc_vld_o,
  output logic [4*IW-1:0]       alloc_idx_o,
  input  logic [3:0]            alloc_rdy_i,
  input  logic [REL_NUM-1:0]    rel_vld_i,
  input  logic [REL_NUM*IW-1:0] rel_idx_i,
  output logic [IW:0]           free_cnt_o,
  output logic                  idle_o,
  output logic                  rel_err_o
);
  import vector_cache_pkg::*;

  localparam int LN = WDB_LANE_NUM;
  localparam int CW = IW + 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } slot_t;

  slot_t                   slot_q [LN];
  slot_t                   slot_d [LN];
  logic [DB_ENTRY_NUM-1:0] free_q, free_d;
  logic [DB_ENTRY_NUM-1:0] pick_mask, rel_set;
  logic [1:0]              rr_q, rr_d;
  logic [CW-1:0]           free_cnt_q;
  logic                    idle_q;
  logic                    rel_err_q, rel_err_d;
  logic [LN-1:0]           need, vld_d;
  logic [LN-1:0]           pos_need, pos_found;
  logic [IW-1:0]           pos_idx  [LN];
  logic [1:0]              pos_lane [LN];
  logic                    served_all;
  logic [IW-1:0]           ridx;
  logic                    illegal;

  always_comb begin
    need = '0;
    for (int i = 0; i < LN; i++) need[i] = !slot_q[i].vld || alloc_rdy_i[i];
  end

  // Position p in the chain serves lane rr_q+p; each stage masks out earlier picks.
  for (genvar p = 0; p < LN; p++) begin : g_pick
    logic [DB_ENTRY_NUM-1:0] mask_in, mask_out;
    logic                    found;
    logic [IW-1:0]           idx;

    if (p == 0) begin : g_first
      assign mask_in = '0;
    end else begin : g_next
      assign mask_in = g_pick[p-1].mask_out;
    end

    assign pos_lane[p] = rr_q + 2'(p);
    assign pos_need[p] = need[pos_lane[p]];

    vec_cache_wdb_pick #(.N(DB_ENTRY_NUM), .IW(IW)) u_pick (
      .avail_i (free_q),
      .mask_i  (mask_in),
      .found_o (found),
      .idx_o   (idx)
    );

    assign mask_out     = (pos_need[p] && found) ?
                          (mask_in | (DB_ENTRY_NUM'(1) << idx)) : mask_in;
    assign pos_found[p] = found;
    assign pos_idx[p]   = idx;
  end

  assign pick_mask = g_pick[LN-1].mask_out;

  always_comb begin
    slot_d     = slot_q;
    served_all = 1'b1;
    for (int p = 0; p < LN; p++) begin
      if (pos_need[p]) begin
        if (pos_found[p]) begin
          slot_d[pos_lane[p]].vld = 1'b1;
          slot_d[pos_lane[p]].idx = pos_idx[p];
        end else begin
          slot_d[pos_lane[p]].vld = 1'b0;
          served_all              = 1'b0;
        end
      end
    end
    rr_d  = served_all ? rr_q : rr_q + 2'd1;
    vld_d = '0;
    for (int i = 0; i < LN; i++) vld_d[i] = slot_d[i].vld;
  end

  always_comb begin
    rel_set   = '0;
    rel_err_d = 1'b0;
    ridx      = '0;
    illegal   = 1'b0;
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
    rel_err_d = rel_err_q;
`endif
    for (int k = 0; k < REL_NUM; k++) begin
      if (rel_vld_i[k]) begin
        ridx = rel_idx_i[k*IW +: IW];
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
        illegal = free_q[ridx];
        for (int i = 0; i < LN; i++) begin
          if (slot_q[i].vld && slot_q[i].idx == ridx) illegal = 1'b1;
        end
        if (illegal) rel_err_d = 1'b1;
        else         rel_set[ridx] = 1'b1;
`else
        rel_set[ridx] = 1'b1;
`endif
      end
    end
  end

  // Picks come from the registered map, so a release only becomes pickable next cycle.
  assign free_d = (free_q & ~pick_mask) | rel_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_q     <= '1;
      for (int i = 0; i < LN; i++) slot_q[i] <= '0;
      rr_q       <= '0;
      free_cnt_q <= CW'(DB_ENTRY_NUM);
      idle_q     <= 1'b1;
      rel_err_q  <= 1'b0;
    end else begin
      free_q     <= free_d;
      slot_q     <= slot_d;
      rr_q       <= rr_d;
      free_cnt_q <= CW'($countones(free_d));
      idle_q     <= ($countones(free_d) + $countones(vld_d)) == DB_ENTRY_NUM;
      rel_err_q  <= rel_err_d;
    end
  end

  for (genvar i = 0; i < LN; i++) begin : g_out
    assign alloc_vld_o[i]           = slot_q[i].vld;
    assign alloc_idx_o[i*IW +: IW]  = slot_q[i].idx;
  end

  assign free_cnt_o = free_cnt_q;
  assign idle_o     = idle_q;
  assign rel_err_o  = rel_err_q;

`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int a = 0; a < LN; a++) begin
        for (int b = a + 1; b < LN; b++) begin
          if (slot_q[a].vld && slot_q[b].vld) assert (slot_q[a].idx != slot_q[b].idx);
        end
      end
      assert (int'(free_cnt_q) <= DB_ENTRY_NUM);
    end
  end
`endif

endmodule

// File: tb/tb_vec_cache_wdb_alloc.sv
// Bench for vec_cache_wdb_alloc: 32-entry instance driven from a vector table,
// 8-entry instance checked every cycle against a queue-based allocation model.
module tb_vec_cache_wdb_alloc;

  localparam int NA = 32, IWA = 5;
  localparam int NB = 8,  IWB = 3;
  localparam int RN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic [3:0]        vld_a, rdy_a, vld_b, rdy_b;
  logic [4*IWA-1:0]  idx_a;
  logic [4*IWB-1:0]  idx_b;
  logic [RN-1:0]     relv_a, relv_b;
  logic [RN*IWA-1:0] reli_a;
  logic [RN*IWB-1:0] reli_b;
  logic [IWA:0]      fc_a;
  logic [IWB:0]      fc_b;
  logic              idle_a, idle_b, err_a, err_b;

  vec_cache_wdb_alloc #(.DB_ENTRY_NUM(NA), .REL_NUM(RN)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .alloc_vld_o(vld_a), .alloc_idx_o(idx_a),
    .alloc_rdy_i(rdy_a), .rel_vld_i(relv_a), .rel_idx_i(reli_a),
    .free_cnt_o(fc_a), .idle_o(idle_a), .rel_err_o(err_a));

  vec_cache_wdb_alloc #(.DB_ENTRY_NUM(NB), .REL_NUM(RN)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .alloc_vld_o(vld_b), .alloc_idx_o(idx_b),
    .alloc_rdy_i(rdy_b), .rel_vld_i(relv_b), .rel_idx_i(reli_b),
    .free_cnt_o(fc_b), .idle_o(idle_b), .rel_err_o(err_b));

`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model for the 8-entry instance ----------------
  bit m_free [NB];
  bit m_vld  [4];
  int m_idx  [4];
  int m_rr;
  int pool[$];   // entries consumed by lanes and not yet returned

  task automatic model_reset();
    for (int e = 0; e < NB; e++) m_free[e] = 1'b1;
    for (int l = 0; l < 4; l++) begin m_vld[l] = 1'b0; m_idx[l] = 0; end
    m_rr = 0;
    pool.delete();
  endtask

  task automatic model_step(input logic [3:0] rdy, input logic [RN-1:0] rv, input int ri[RN]);
    int avail[$];
    bit unserved;
    int l;
    unserved = 1'b0;
    for (int e = 0; e < NB; e++) if (m_free[e]) avail.push_back(e);
    for (int p = 0; p < 4; p++) begin
      l = (m_rr + p) % 4;
      if (!m_vld[l] || rdy[l]) begin
        if (m_vld[l]) pool.push_back(m_idx[l]);
        if (avail.size() > 0) begin
          m_idx[l] = avail.pop_front();
          m_vld[l] = 1'b1;
          m_free[m_idx[l]] = 1'b0;
        end else begin
          m_vld[l] = 1'b0;
          unserved = 1'b1;
        end
      end
    end
    if (unserved) m_rr = (m_rr + 1) % 4;
    for (int k = 0; k < RN; k++) if (rv[k]) m_free[ri[k]] = 1'b1;
  endtask

  task automatic compare_b();
    int nf, nv;
    nf = 0; nv = 0;
    for (int e = 0; e < NB; e++) nf += int'(m_free[e]);
    for (int l = 0; l < 4; l++) begin
      nv += int'(m_vld[l]);
      chk($sformatf("b_vld%0d", l), 32'(vld_b[l]), 32'(m_vld[l]));
      if (m_vld[l]) chk($sformatf("b_idx%0d", l), 32'(idx_b[l*IWB +: IWB]), 32'(m_idx[l]));
    end
    chk("b_free_cnt", 32'(fc_b), 32'(nf));
    chk("b_idle", 32'(idle_b), 32'(nf + nv == NB));
    chk("b_rel_err", 32'(err_b), 32'd0);
  endtask

  task automatic cycle_b(input logic [3:0] rdy, input logic [RN-1:0] rv, input int ri[RN]);
    rdy_b  = rdy;
    relv_b = rv;
    for (int k = 0; k < RN; k++) reli_b[k*IWB +: IWB] = IWB'(ri[k]);
    model_step(rdy, rv, ri);
    @(posedge clk); #1;
    compare_b();
  endtask

  // Pull a given entry out of the outstanding pool (it is about to be released).
  task automatic pool_take(input int e);
    for (int j = 0; j < pool.size(); j++) begin
      if (pool[j] == e) begin pool.delete(j); return; end
    end
  endtask

  // ---------------- vector table for the 32-entry instance ----------------
  typedef struct {
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [4:0]  idx0;
    logic [14:0] idx_hi;   // {lane3, lane2, lane1}
    logic [5:0]  free;
    logic        idle;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ri[RN];
    int zr[RN];
    logic [RN-1:0] rv;

    for (int k = 0; k < RN; k++) zr[k] = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    rdy_a = '0; relv_a = '0; reli_a = '0;
    rdy_b = '0; relv_b = '0; reli_b = '0;

    tbl[0] = '{4'b0000, 4'hF, 5'd0, {5'd3, 5'd2, 5'd1},  6'd28, 1'b1};
    tbl[1] = '{4'b0001, 4'hF, 5'd4, {5'd3, 5'd2, 5'd1},  6'd27, 1'b0};
    tbl[2] = '{4'b0001, 4'hF, 5'd5, {5'd3, 5'd2, 5'd1},  6'd26, 1'b0};
    tbl[3] = '{4'b0001, 4'hF, 5'd6, {5'd3, 5'd2, 5'd1},  6'd25, 1'b0};
    tbl[4] = '{4'b0001, 4'hF, 5'd7, {5'd3, 5'd2, 5'd1},  6'd24, 1'b0};
    tbl[5] = '{4'b0000, 4'hF, 5'd7, {5'd3, 5'd2, 5'd1},  6'd24, 1'b0};
    tbl[6] = '{4'b0010, 4'hF, 5'd7, {5'd3, 5'd2, 5'd8},  6'd23, 1'b0};
    tbl[7] = '{4'b1100, 4'hF, 5'd7, {5'd10, 5'd9, 5'd8}, 6'd21, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_vld",  32'(vld_a),  32'd0);
    chk("a_rst_free", 32'(fc_a),   32'd32);
    chk("a_rst_idle", 32'(idle_a), 32'd1);
    chk("a_rst_err",  32'(err_a),  32'd0);
    chk("b_rst_free", 32'(fc_b),   32'd8);
    rst_a = 1'b0;

    for (int t = 0; t < 8; t++) begin
      rdy_a = tbl[t].rdy;
      @(posedge clk); #1;
      chk($sformatf("a_t%0d_vld", t),  32'(vld_a),          32'(tbl[t].vld));
      chk($sformatf("a_t%0d_idx0", t), 32'(idx_a[4:0]),     32'(tbl[t].idx0));
      chk($sformatf("a_t%0d_idxh", t), 32'(idx_a[19:5]),    32'(tbl[t].idx_hi));
      chk($sformatf("a_t%0d_free", t), 32'(fc_a),           32'(tbl[t].free));
      chk($sformatf("a_t%0d_idle", t), 32'(idle_a),         32'(tbl[t].idle));
    end
    rdy_a = '0;

    // Returning an entry that is already free must not change the count.
    relv_a = 4'b0001; reli_a = '0; reli_a[4:0] = 5'd20;
    @(posedge clk); #1;
    relv_a = '0;
    chk("a_badrel_free", 32'(fc_a),  32'd21);
    chk("a_badrel_err",  32'(err_a), 32'(EXP_ERR));
    // Legal return of consumed entry 0; error flag is sticky.
    relv_a = 4'b0001; reli_a[4:0] = 5'd0;
    @(posedge clk); #1;
    relv_a = '0;
    chk("a_goodrel_free", 32'(fc_a),  32'd22);
    chk("a_sticky_err",   32'(err_a), 32'(EXP_ERR));
    @(posedge clk); #1;
    chk("a_sticky_err2",  32'(err_a), 32'(EXP_ERR));

    // ---------------- 8-entry instance: exhaustion and rotation ----------------
    rst_b = 1'b0;
    model_reset();
    cycle_b(4'h0, '0, zr);
    chk("b_first_vld",  32'(vld_b), 32'hF);
    chk("b_first_idx",  32'(idx_b), 32'({3'd3, 3'd2, 3'd1, 3'd0}));
    chk("b_first_free", 32'(fc_b),  32'd4);
    cycle_b(4'hF, '0, zr);
    cycle_b(4'hF, '0, zr);
    chk("b_exh_vld",  32'(vld_b),  32'd0);
    chk("b_exh_free", 32'(fc_b),   32'd0);
    chk("b_exh_idle", 32'(idle_b), 32'd0);

    ri = zr; ri[0] = 5; pool_take(5);
    cycle_b(4'h0, 4'b0001, ri);
    chk("b_rel5_free", 32'(fc_b),  32'd1);
    chk("b_rel5_vld",  32'(vld_b), 32'd0);
    cycle_b(4'h0, '0, zr);
    chk("b_rel5_offer_vld", 32'(vld_b),     32'b0100);
    chk("b_rel5_offer_idx", 32'(idx_b[8:6]), 32'd5);

    for (int r = 0; r < 3; r++) begin
      ri = zr; ri[0] = pool.pop_front();
      cycle_b(4'h0, 4'b0001, ri);
      cycle_b(4'h0, '0, zr);
    end

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 600; c++) begin
      rv = '0;
      ri = zr;
      for (int k = 0; k < RN; k++) begin
        if (pool.size() > 0 && $urandom_range(2) == 0) begin
          int j;
          j = $urandom_range(pool.size() - 1);
          ri[k] = pool[j];
          pool.delete(j);
          rv[k] = 1'b1;
        end else if (k > 0 && rv[k-1] && $urandom_range(7) == 0) begin
          ri[k] = ri[k-1];
          rv[k] = 1'b1;
        end
      end
      cycle_b(4'($urandom_range(15)), rv, ri);
    end

    // ---------------- return everything ----------------
    for (int g = 0; g < 20 && pool.size() > 0; g++) begin
      rv = '0;
      ri = zr;
      for (int k = 0; k < RN; k++) begin
        if (pool.size() > 0) begin
          ri[k] = pool.pop_front();
          rv[k] = 1'b1;
        end
      end
      cycle_b(4'h0, rv, ri);
    end
    repeat (3) cycle_b(4'h0, '0, zr);
    chk("b_drain_idle", 32'(idle_b), 32'd1);
    chk("b_drain_free", 32'(fc_b),   32'd4);
    chk("b_drain_vld",  32'(vld_b),  32'hF);

    // Consume some entries, then reset asynchronously between edges.
    cycle_b(4'hF, '0, zr);
    rst_b = 1'b1;
    #1;
    chk("b_async_vld",  32'(vld_b),  32'd0);
    chk("b_async_free", 32'(fc_b),   32'd8);
    chk("b_async_idle", 32'(idle_b), 32'd1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    model_reset();
    cycle_b(4'h0, '0, zr);
    chk("b_post_rst_idx", 32'(idx_b), 32'({3'd3, 3'd2, 3'd1, 3'd0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
